wash_sense_timer: RTL and testbench

- Sensor-conditioning and timing stage that sits directly upstream of the washing-machine control FSM.
- Synchronises and debounces the raw tank-level sensors into filled/drained.
- Times the wash agitation and spin phases from the FSM's motor_on and drain_value_on outputs, and returns cycle_timeout and spin_timeout.
- Flags a sticky fault when filling or draining runs too long.

---
 rtl/wash_sense_timer.sv | 238 +++++++++++++++++++++++
 tb/tb_wash_sense_timer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sense_timer.sv
// wash_sense_timer
// Sensor-conditioning and phase-timing stage in front of the washing-machine
// control FSM.
//
// Ports
//   clk            in   system clock, all logic on the rising edge
//   reset          in   asynchronous active-low reset
//   level_high_raw in   raw tank-full sensor, asynchronous
//   empty_raw      in   raw tank-empty sensor, asynchronous
//   motor_on       in   control FSM: agitation motor running
//   fill_value_on  in   control FSM: fill valve open
//   drain_value_on in   control FSM: drain valve open
//   filled         out  debounced level_high_raw
//   drained        out  debounced empty_raw
//   cycle_timeout  out  wash duration elapsed (held until WASH is left)
//   spin_timeout   out  spin duration elapsed (held until SPIN is left)
//   fault          out  sticky fill/drain watchdog fault
//   sec_count      out  tick count of the current phase
//
// Timer FSM
//   state   | meaning
//   ST_IDLE | no phase active, prescaler and sec_count held at 0
//   ST_WASH | agitation timing, stays while motor_on=1
//   ST_SPIN | spin timing, stays while drain_value_on=1 and drained=1
module wash_sense_timer #(
    parameter int unsigned TICK_DIV      = 50000000,
    parameter int unsigned CYCLE_SEC     = 600,
    parameter int unsigned SPIN_SEC      = 300,
    parameter int unsigned DEB_CYC       = 16,
    parameter int unsigned FILL_MAX_SEC  = 240,
    parameter int unsigned DRAIN_MAX_SEC = 180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        level_high_raw,
    input  logic        empty_raw,
    input  logic        motor_on,
    input  logic        fill_value_on,
    input  logic        drain_value_on,
    output logic        filled,
    output logic        drained,
    output logic        cycle_timeout,
    output logic        spin_timeout,
    output logic        fault,
    output logic [15:0] sec_count
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DW = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;

    localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_TC   = DW'(DEB_CYC - 1);
    localparam logic [15:0]   CYCLE_TC = 16'(CYCLE_SEC);
    localparam logic [15:0]   SPIN_TC  = 16'(SPIN_SEC);
    localparam logic [15:0]   FILL_TC  = 16'(FILL_MAX_SEC);
    localparam logic [15:0]   DRAIN_TC = 16'(DRAIN_MAX_SEC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WASH = 2'd1,
        ST_SPIN = 2'd2
    } state_t;

    // synchronisers
    logic lvl_meta_q, lvl_sync_q, emp_meta_q, emp_sync_q;

    // debounce
    logic [DW-1:0] lvl_cnt_q, lvl_cnt_d;
    logic [DW-1:0] emp_cnt_q, emp_cnt_d;
    logic          filled_q, filled_d;
    logic          drained_q, drained_d;

    // phase timer
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   sec_q, sec_d;
    logic          cycle_to_q, cycle_to_d;
    logic          spin_to_q, spin_to_d;

    // watchdogs
    logic [PW-1:0] fill_presc_q, fill_presc_d;
    logic [15:0]   fill_sec_q, fill_sec_d;
    logic [PW-1:0] drain_presc_q, drain_presc_d;
    logic [15:0]   drain_sec_q, drain_sec_d;
    logic          fault_q, fault_d;

    logic wash_stay, spin_stay, fill_run, drain_run;

    always_comb begin
        // Debounce: the count only survives while the synchronised value
        // disagrees with the output; the DEB_CYC-th disagreeing cycle flips it.
        lvl_cnt_d = '0;
        filled_d  = filled_q;
        if (lvl_sync_q != filled_q) begin
            if (lvl_cnt_q == DEB_TC) begin
                filled_d = ~filled_q;
            end else begin
                lvl_cnt_d = lvl_cnt_q + 1'b1;
            end
        end

        emp_cnt_d = '0;
        drained_d = drained_q;
        if (emp_sync_q != drained_q) begin
            if (emp_cnt_q == DEB_TC) begin
                drained_d = ~drained_q;
            end else begin
                emp_cnt_d = emp_cnt_q + 1'b1;
            end
        end

        // Phase timer
        wash_stay = (state_q == ST_WASH) && motor_on;
        spin_stay = (state_q == ST_SPIN) && drain_value_on && drained_q;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (motor_on) begin
                    state_d = ST_WASH;
                end else if (drain_value_on && drained_q) begin
                    state_d = ST_SPIN;
                end
            end
            ST_WASH: if (!wash_stay) state_d = ST_IDLE;
            ST_SPIN: if (!spin_stay) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Anything other than remaining in an active phase (idle, entry or
        // exit) clears the counters, which also discards a tick that would
        // have fired on an exit edge.
        presc_d = presc_q;
        sec_d   = sec_q;
        if (!(wash_stay || spin_stay)) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (!(cycle_to_q || spin_to_q)) begin
            if (presc_q == PRESC_TC) begin
                presc_d = '0;
                if (sec_q != 16'hFFFF) begin
                    sec_d = sec_q + 16'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        cycle_to_d = wash_stay && (cycle_to_q || (sec_d == CYCLE_TC));
        spin_to_d  = spin_stay && (spin_to_q  || (sec_d == SPIN_TC));

        // Watchdogs: each has its own prescaler so a phase entry never
        // disturbs a running fill/drain measurement.
        fill_run     = fill_value_on && !filled_q;
        fill_presc_d = fill_presc_q;
        fill_sec_d   = fill_sec_q;
        if (!fill_run) begin
            fill_presc_d = '0;
            fill_sec_d   = '0;
        end else if (fill_sec_q != FILL_TC) begin
            if (fill_presc_q == PRESC_TC) begin
                fill_presc_d = '0;
                fill_sec_d   = fill_sec_q + 16'd1;
            end else begin
                fill_presc_d = fill_presc_q + 1'b1;
            end
        end

        drain_run     = drain_value_on && !drained_q;
        drain_presc_d = drain_presc_q;
        drain_sec_d   = drain_sec_q;
        if (!drain_run) begin
            drain_presc_d = '0;
            drain_sec_d   = '0;
        end else if (drain_sec_q != DRAIN_TC) begin
            if (drain_presc_q == PRESC_TC) begin
                drain_presc_d = '0;
                drain_sec_d   = drain_sec_q + 16'd1;
            end else begin
                drain_presc_d = drain_presc_q + 1'b1;
            end
        end

        fault_d = fault_q
                | (fill_run  && (fill_sec_d  == FILL_TC))
                | (drain_run && (drain_sec_d == DRAIN_TC));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lvl_meta_q    <= 1'b0;
            lvl_sync_q    <= 1'b0;
            emp_meta_q    <= 1'b0;
            emp_sync_q    <= 1'b0;
            lvl_cnt_q     <= '0;
            emp_cnt_q     <= '0;
            filled_q      <= 1'b0;
            drained_q     <= 1'b0;
            state_q       <= ST_IDLE;
            presc_q       <= '0;
            sec_q         <= '0;
            cycle_to_q    <= 1'b0;
            spin_to_q     <= 1'b0;
            fill_presc_q  <= '0;
            fill_sec_q    <= '0;
            drain_presc_q <= '0;
            drain_sec_q   <= '0;
            fault_q       <= 1'b0;
        end else begin
            lvl_meta_q    <= level_high_raw;
            lvl_sync_q    <= lvl_meta_q;
            emp_meta_q    <= empty_raw;
            emp_sync_q    <= emp_meta_q;
            lvl_cnt_q     <= lvl_cnt_d;
            emp_cnt_q     <= emp_cnt_d;
            filled_q      <= filled_d;
            drained_q     <= drained_d;
            state_q       <= state_d;
            presc_q       <= presc_d;
            sec_q         <= sec_d;
            cycle_to_q    <= cycle_to_d;
            spin_to_q     <= spin_to_d;
            fill_presc_q  <= fill_presc_d;
            fill_sec_q    <= fill_sec_d;
            drain_presc_q <= drain_presc_d;
            drain_sec_q   <= drain_sec_d;
            fault_q       <= fault_d;
        end
    end

    assign filled        = filled_q;
    assign drained       = drained_q;
    assign cycle_timeout = cycle_to_q;
    assign spin_timeout  = spin_to_q;
    assign fault         = fault_q;
    assign sec_count     = sec_q;

endmodule

// File: tb/tb_wash_sense_timer.sv
// Testbench for wash_sense_timer: directed scenarios followed by random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_wash_sense_timer;

    localparam int TD    = 4;
    localparam int CYC   = 3;
    localparam int SPN   = 2;
    localparam int DEB   = 3;
    localparam int FMAX  = 5;
    localparam int DMAX  = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        level_high_raw = 1'b0;
    logic        empty_raw = 1'b0;
    logic        motor_on = 1'b0;
    logic        fill_value_on = 1'b0;
    logic        drain_value_on = 1'b0;
    logic        filled, drained, cycle_timeout, spin_timeout, fault;
    logic [15:0] sec_count;

    int n_checks = 0;
    int n_errors = 0;

    wash_sense_timer #(
        .TICK_DIV(TD), .CYCLE_SEC(CYC), .SPIN_SEC(SPN), .DEB_CYC(DEB),
        .FILL_MAX_SEC(FMAX), .DRAIN_MAX_SEC(DMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .level_high_raw(level_high_raw), .empty_raw(empty_raw),
        .motor_on(motor_on), .fill_value_on(fill_value_on),
        .drain_value_on(drain_value_on),
        .filled(filled), .drained(drained),
        .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout),
        .fault(fault), .sec_count(sec_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase is tracked as "which phase, and how many edges spent in it";
    // ticks, sec_count and timeouts follow from integer division.
    int m_phase;          // 0 idle, 1 wash, 2 spin
    int m_n;              // edges since phase entry
    int fill_len, drain_len;
    bit m_fault, m_filled, m_drained;
    bit lvl_h[$];
    bit emp_h[$];

    task automatic model_reset();
        m_phase = 0; m_n = 0; fill_len = 0; drain_len = 0;
        m_fault = 0; m_filled = 0; m_drained = 0;
        lvl_h.delete(); emp_h.delete();
        for (int i = 0; i < DEB + 3; i++) begin
            lvl_h.push_back(1'b0);
            emp_h.push_back(1'b0);
        end
    endtask

    // h holds raw samples taken at each edge, newest last. The value that
    // has cleared the synchroniser at this edge is the one taken two edges
    // earlier; the output flips when the last DEB such values all disagree.
    function automatic bit deb_flip(input bit h[$], input bit cur);
        for (int i = 0; i < DEB; i++)
            if (h[h.size() - 3 - i] == cur) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            bit stay;
            stay = (m_phase == 1 && motor_on) ||
                   (m_phase == 2 && drain_value_on && m_drained);
            if (stay) begin
                if (m_n < 1000000) m_n++;
            end else begin
                m_n = 0;
                if (m_phase != 0)                      m_phase = 0;
                else if (motor_on)                     m_phase = 1;
                else if (drain_value_on && m_drained)  m_phase = 2;
            end

            fill_len  = (fill_value_on  && !m_filled)  ? fill_len + 1  : 0;
            drain_len = (drain_value_on && !m_drained) ? drain_len + 1 : 0;
            if (fill_len >= FMAX * TD || drain_len >= DMAX * TD) m_fault = 1'b1;

            lvl_h.push_back(level_high_raw);
            emp_h.push_back(empty_raw);
            if (deb_flip(lvl_h, m_filled))  m_filled  = ~m_filled;
            if (deb_flip(emp_h, m_drained)) m_drained = ~m_drained;
            if (lvl_h.size() > 32) lvl_h.delete(0);
            if (emp_h.size() > 32) emp_h.delete(0);
        end
    end

    always @(negedge clk) begin
        int lim, e_sec;
        lim   = (m_phase == 1) ? CYC : SPN;
        e_sec = (m_phase == 0) ? 0 : ((m_n / TD < lim) ? m_n / TD : lim);
        chk("m_filled",  {31'b0, filled},        {31'b0, m_filled});
        chk("m_drained", {31'b0, drained},       {31'b0, m_drained});
        chk("m_cyc_to",  {31'b0, cycle_timeout}, {31'b0, (m_phase == 1 && m_n >= CYC * TD)});
        chk("m_spin_to", {31'b0, spin_timeout},  {31'b0, (m_phase == 2 && m_n >= SPN * TD)});
        chk("m_fault",   {31'b0, fault},         {31'b0, m_fault});
        chk("m_sec",     {16'b0, sec_count},     32'(e_sec));
    end

    // ---------------- stimulus ----------------
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {26'b0, filled, drained, cycle_timeout, spin_timeout, fault, 1'b0}, 32'd0);
        chk(tag, {16'b0, sec_count}, 32'd0);
    endtask

    initial begin
        model_reset();
        #2;
        chk_all_zero("reset_state");
        edges(2);
        reset = 1'b1;
        edges(2);

        // 1. debounce latency and glitch rejection
        level_high_raw = 1'b1;
        edges(4);  chk("filled_early", {31'b0, filled}, 32'd0);
        edges(1);  chk("filled_at5",   {31'b0, filled}, 32'd1);
        empty_raw = 1'b1;
        edges(2);
        empty_raw = 1'b0;
        edges(8);  chk("glitch_drained", {31'b0, drained}, 32'd0);

        // 2. wash timing
        motor_on = 1'b1;
        edges(12); chk("wash_to_e11", {31'b0, cycle_timeout}, 32'd0);
        edges(1);  chk("wash_to_e12", {31'b0, cycle_timeout}, 32'd1);
        edges(3);  chk("wash_to_hold", {31'b0, cycle_timeout}, 32'd1);
        chk("wash_sec_hold", {16'b0, sec_count}, 32'd3);
        motor_on = 1'b0;
        edges(1);  chk("wash_exit_to", {31'b0, cycle_timeout}, 32'd0);
        chk("wash_exit_sec", {16'b0, sec_count}, 32'd0);

        // 3. spin timing and abort on drained loss
        empty_raw = 1'b1;
        edges(6);  chk("drained_set", {31'b0, drained}, 32'd1);
        drain_value_on = 1'b1;
        edges(8);  chk("spin_to_e7", {31'b0, spin_timeout}, 32'd0);
        edges(1);  chk("spin_to_e8", {31'b0, spin_timeout}, 32'd1);
        drain_value_on = 1'b0;
        edges(1);  chk("spin_exit", {31'b0, spin_timeout}, 32'd0);
        drain_value_on = 1'b1;
        edges(1);
        empty_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            chk("spin_abort", {31'b0, spin_timeout}, 32'd0);
        end
        chk("spin_abort_sec", {16'b0, sec_count}, 32'd0);
        drain_value_on = 1'b0;
        edges(2);

        // 4. WASH has priority over SPIN
        empty_raw = 1'b1;
        edges(6);
        motor_on = 1'b1;
        drain_value_on = 1'b1;
        edges(13);
        chk("prio_cyc_to",  {31'b0, cycle_timeout}, 32'd1);
        chk("prio_spin_to", {31'b0, spin_timeout},  32'd0);
        motor_on = 1'b0;
        drain_value_on = 1'b0;
        edges(2);

        // 5. fill watchdog
        chk("fault_pre", {31'b0, fault}, 32'd0);
        level_high_raw = 1'b0;
        edges(6);  chk("filled_clr", {31'b0, filled}, 32'd0);
        fill_value_on = 1'b1;
        edges(19); chk("fault_e19", {31'b0, fault}, 32'd0);
        edges(1);  chk("fault_e20", {31'b0, fault}, 32'd1);
        fill_value_on = 1'b0;
        edges(4);  chk("fault_sticky", {31'b0, fault}, 32'd1);

        // 6. asynchronous reset mid-wash
        motor_on = 1'b1;
        edges(7);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk_all_zero("async_reset");
        edges(2);
        reset = 1'b1;
        edges(12); chk("rewash_e11", {31'b0, cycle_timeout}, 32'd0);
        edges(1);  chk("rewash_e12", {31'b0, cycle_timeout}, 32'd1);
        motor_on = 1'b0;
        edges(2);

        // random phase
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5)  == 0) level_high_raw = ~level_high_raw;
            if ($urandom_range(0, 5)  == 0) empty_raw      = ~empty_raw;
            if ($urandom_range(0, 29) == 0) motor_on       = ~motor_on;
            if ($urandom_range(0, 19) == 0) fill_value_on  = ~fill_value_on;
            if ($urandom_range(0, 19) == 0) drain_value_on = ~drain_value_on;
            if ($urandom_range(0, 399) == 0) begin
                #2;
                reset = 1'b0;
                model_reset();
                #1;
                chk_all_zero("rand_reset");
                edges($urandom_range(1, 3));
                reset = 1'b1;
            end
        end

        edges(2);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
